// File: rtl/keyboard_event_controller_if.sv
// Bus between the PS/2 byte source / CPU-side register logic and the
// keyboard event controller.
interface keyboard_event_controller_if;
  logic [7:0] scancode;
  logic       ready;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_release;
  logic       event_valid;
  logic       event_pop;
  logic [2:0] modifiers;
  logic       overflow;
  logic       clear_overflow;

  modport master (
    output scancode, ready, event_pop, clear_overflow,
    input  event_code, event_extended, event_release, event_valid,
           modifiers, overflow
  );

  modport slave (
    input  scancode, ready, event_pop, clear_overflow,
    output event_code, event_extended, event_release, event_valid,
           modifiers, overflow
  );
endinterface

// File: rtl/keyboard_event_controller.sv
// Turns the raw PS/2 byte stream into {ext, rel, code} key events, tracks
// held modifiers and queues events for the CPU to pop.
module keyboard_event_controller #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  keyboard_event_controller_if.slave    kbd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       done;
  kbd_event_t ev;
  logic       err_byte;

  assign err_byte = (kbd.scancode == 8'h00) || (kbd.scancode == 8'hFF);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    done      = 1'b0;
    ev.ext    = 1'b0;
    ev.rel    = 1'b0;
    ev.code   = kbd.scancode;
    if (kbd.ready) begin
      case (state)
        IDLE: begin
          case (kbd.scancode)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = PAUSE;
              skip_nxt  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: done = 1'b1;
          endcase
        end
        EXT: begin
          if (kbd.scancode == 8'hF0)      state_nxt = EXT_BRK;
          else if (kbd.scancode == 8'hE0) state_nxt = EXT;
          else if (err_byte)              state_nxt = IDLE;
          else begin
            done      = 1'b1;
            ev.ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          if (kbd.scancode == 8'hE0)      state_nxt = EXT_BRK;
          else if (kbd.scancode == 8'hF0) state_nxt = BRK;
          else if (err_byte)              state_nxt = IDLE;
          else begin
            done      = 1'b1;
            ev.rel    = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT_BRK: begin
          if (kbd.scancode == 8'hE0 || kbd.scancode == 8'hF0) state_nxt = EXT_BRK;
          else if (err_byte) state_nxt = IDLE;
          else begin
            done      = 1'b1;
            ev.ext    = 1'b1;
            ev.rel    = 1'b1;
            state_nxt = IDLE;
          end
        end
        PAUSE: begin
          // The whole E1 tail is swallowed; its last byte stands in for the key.
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            done      = 1'b1;
            ev.code   = 8'hE1;
            skip_nxt  = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          skip_nxt  = '0;
        end
      endcase
    end
  end

  // Modifier tracking follows every decoded event, even ones the queue drops.
  logic [2:0] mods;
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) mods <= '0;
    else if (done) begin
      case (ev.code)
        8'h12, 8'h59: if (!ev.ext) mods[0] <= ~ev.rel;
        8'h14:        mods[1] <= ~ev.rel;
        8'h11:        mods[2] <= ~ev.rel;
        default: ;
      endcase
    end
  end

  kbd_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop_ok, push_ok, ovf_set, ovf;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = kbd.event_pop && !empty;
  assign push_ok = done && (!full || pop_ok);
  assign ovf_set = done && full && !pop_ok;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (ovf_set)  ovf <= 1'b1;
    else if (kbd.clear_overflow) ovf <= 1'b0;
  end

  // Storage is not reset, so head fields are masked while the queue is empty.
  kbd_event_t head;
  assign head               = mem[rd_ptr];
  assign kbd.event_valid    = !empty;
  assign kbd.event_code     = empty ? 8'h00 : head.code;
  assign kbd.event_extended = !empty && head.ext;
  assign kbd.event_release  = !empty && head.rel;
  assign kbd.modifiers      = mods;
  assign kbd.overflow       = ovf;
endmodule

// File: tb/tb_keyboard_event_controller.sv
// Table-driven, hand-sequenced and randomized checks of the keyboard event
// controller against a queue-based reference model.
module tb_keyboard_event_controller;
  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  keyboard_event_controller_if kif();

  keyboard_event_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .kbd      (kif.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [14:0] e(bit v, bit x, bit r, logic [7:0] c, logic [2:0] m, bit o);
    return {v, x, r, c, m, o};
  endfunction

  function automatic logic [14:0] obs();
    return {kif.event_valid, kif.event_extended, kif.event_release,
            kif.event_code, kif.modifiers, kif.overflow};
  endfunction

  // Reference model: pending-prefix flags, a bytes-left counter for the
  // pause tail, and a plain queue of {ext, rel, code}.
  logic [9:0] mq[$];
  bit         pext, pbrk, movf;
  int         pause_left;
  logic [2:0] mmods;

  function automatic void model_reset();
    mq.delete();
    pext = 0; pbrk = 0; movf = 0; pause_left = 0; mmods = '0;
  endfunction

  function automatic void model_step(bit r, logic [7:0] b, bit p, bit c);
    bit done = 0;
    logic [9:0] ev = '0;
    bit ovf_set = 0;
    if (r) begin
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) begin done = 1; ev = {2'b00, 8'hE1}; end
      end else if (b == 8'h00 || b == 8'hFF) begin
        pext = 0; pbrk = 0;
      end else if (b == 8'hE0) pext = 1;
      else if (b == 8'hF0) pbrk = 1;
      else if (!pext && !pbrk && b == 8'hE1) pause_left = 7;
      else if (!pext && !pbrk && (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) ;
      else begin
        done = 1; ev = {pext, pbrk, b}; pext = 0; pbrk = 0;
      end
    end
    if (done) begin
      if ((ev[7:0] == 8'h12 || ev[7:0] == 8'h59) && !ev[9]) mmods[0] = !ev[8];
      if (ev[7:0] == 8'h14) mmods[1] = !ev[8];
      if (ev[7:0] == 8'h11) mmods[2] = !ev[8];
    end
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else ovf_set = 1;
    end
    if (ovf_set) movf = 1;
    else if (c) movf = 0;
  endfunction

  function automatic logic [14:0] mexp();
    logic [9:0] h = (mq.size() > 0) ? mq[0] : 10'h0;
    return {mq.size() > 0, h, mmods, movf};
  endfunction

  task automatic cyc(input bit r, input logic [7:0] b, input bit p, input bit c);
    kif.ready = r; kif.scancode = b; kif.event_pop = p; kif.clear_overflow = c;
    @(posedge CLOCK_50);
    model_step(r, b, p, c);
    #1;
    kif.ready = 0; kif.event_pop = 0; kif.clear_overflow = 0;
    chk("model", obs(), mexp());
  endtask

  typedef struct {
    bit          r;
    logic [7:0]  sc;
    bit          p;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, logic [7:0] sc, bit p, logic [14:0] ex);
    vec_t v;
    v.r = r; v.sc = sc; v.p = p; v.exp = ex;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 15))
      0: return 8'hE0;  1: return 8'hF0;  2: return 8'hE1;  3: return 8'hAA;
      4: return 8'h00;  5: return 8'hFF;  6: return 8'h12;  7: return 8'h59;
      8: return 8'h14;  9: return 8'h11;  10: return 8'hFA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] drain_exp[8];
    kif.ready = 0; kif.scancode = '0; kif.event_pop = 0; kif.clear_overflow = 0;
    model_reset();
    #3 chk("reset_outputs", obs(), 15'h0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1 rst_n = 1'b1;

    // make, extended make, break, extended break
    add(1, 8'h1C, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'hE0, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'h75, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'hF0, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'h1C, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'hE0, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'hF0, 0, e(1,0,0,8'h1C,3'b000,0));
    add(1, 8'h75, 0, e(1,0,0,8'h1C,3'b000,0));
    add(0, 8'h00, 1, e(1,1,0,8'h75,3'b000,0));
    add(0, 8'h00, 1, e(1,0,1,8'h1C,3'b000,0));
    add(0, 8'h00, 1, e(1,1,1,8'h75,3'b000,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b000,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b000,0));   // pop on empty ignored
    // status bytes and an aborted E0 prefix
    add(1, 8'hAA, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hFA, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hE0, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hFF, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'h1C, 0, e(1,0,0,8'h1C,3'b000,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b000,0));
    // pause sequence
    add(1, 8'hE1, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'h14, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'h77, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hE1, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hF0, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'h14, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'hF0, 0, e(0,0,0,8'h00,3'b000,0));
    add(1, 8'h77, 0, e(1,0,0,8'hE1,3'b000,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b000,0));
    // modifiers: shift, ctrl, shift release
    add(1, 8'h12, 0, e(1,0,0,8'h12,3'b001,0));
    add(1, 8'h14, 0, e(1,0,0,8'h12,3'b011,0));
    add(1, 8'hF0, 0, e(1,0,0,8'h12,3'b011,0));
    add(1, 8'h12, 0, e(1,0,0,8'h12,3'b010,0));
    add(0, 8'h00, 1, e(1,0,0,8'h14,3'b010,0));
    add(0, 8'h00, 1, e(1,0,1,8'h12,3'b010,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b010,0));
    add(1, 8'hF0, 0, e(0,0,0,8'h00,3'b010,0));
    add(1, 8'h14, 0, e(1,0,1,8'h14,3'b000,0));
    add(0, 8'h00, 1, e(0,0,0,8'h00,3'b000,0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].sc, tbl[i].p, 1'b0);
      chk($sformatf("tbl[%0d]", i), obs(), tbl[i].exp);
    end

    // Overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++) cyc(1, 8'(32 + i), 0, 0);
    chk("ovf_set", 15'(kif.overflow), 15'd1);
    chk("ovf_head", obs(), e(1,0,0,8'h20,3'b000,1));
    cyc(0, 8'h00, 0, 1);
    chk("ovf_clear", 15'(kif.overflow), 15'd0);
    cyc(1, 8'h30, 1, 0);
    chk("full_pop_push_ovf", 15'(kif.overflow), 15'd0);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'(33 + i);
    drain_exp[7] = 8'h30;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain[%0d]", i), obs(), e(1,0,0,drain_exp[i],3'b000,0));
      cyc(0, 8'h00, 1, 0);
    end
    chk("drain_empty", 15'(kif.event_valid), 15'd0);

    // Async reset with queued events, held ctrl and a pending E0
    cyc(1, 8'h14, 0, 0);
    cyc(1, 8'h1C, 0, 0);
    cyc(1, 8'hE0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), 15'h0);
    model_reset();
    @(posedge CLOCK_50); #1 rst_n = 1'b1;
    cyc(1, 8'h1C, 0, 0);
    chk("post_reset_event", obs(), e(1,0,0,8'h1C,3'b000,0));
    cyc(0, 8'h00, 1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6, rnd_byte(),
          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
